// File: rtl/slow_clk_pkg.sv
// Shared types and defaults for the slow-clock monitor.
package slow_clk_pkg;

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_t;

   localparam int SLOW_CLK_PERIOD_DEFAULT = 15362;
   localparam int SLOW_CLK_TOL_DEFAULT    = 16;
   localparam int SLOW_CLK_LOCK_DEFAULT   = 4;

   // Inclusive window test used to classify a measured period.
   function automatic logic in_window(input logic [31:0] v,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by an edge register. Every flop resets
// to 1 so an input that is already high at reset never produces a rise.
module sync_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   // Synchronizer chain plus the previous-value register for edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow-clock monitor: synchronizes slow_clk_in, pulses tick on each rising
// edge, measures the tick spacing in clk cycles and tracks lock.
// Build option: SLOW_CLK_MON_STICKY_FAULT_EN makes fault sticky (cleared by
// clr_fault); without it fault is a one-cycle pulse and clr_fault is unused.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACQUIRE | no reference edge yet; first tick starts measurement
// MEASURE | counting consecutive good periods toward LOCK_COUNT
// LOCKED  | LOCK_COUNT good periods seen; any bad period drops lock
module slow_clk_monitor
   import slow_clk_pkg::*;
#(
   parameter int EXPECTED_PERIOD = SLOW_CLK_PERIOD_DEFAULT,
   parameter int TOLERANCE       = SLOW_CLK_TOL_DEFAULT,
   parameter int LOCK_COUNT      = SLOW_CLK_LOCK_DEFAULT,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             slow_clk_in,
   input  logic             clr_fault,
   output logic             tick,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             fault
);

   localparam int unsigned     LO_I = EXPECTED_PERIOD - TOLERANCE;
   localparam int unsigned     HI_I = EXPECTED_PERIOD + TOLERANCE;
   localparam logic [CNT_W-1:0] HI  = CNT_W'(HI_I);
   localparam logic [3:0]      LOCK_LAST = 4'(LOCK_COUNT - 1);

   mon_state_t       state;
   logic [3:0]       good_cnt;
   logic [CNT_W-1:0] cnt;
   logic             rise;
   logic             good_per;
   logic             timeout;
   logic             fault_ev;

   sync_rise_detect u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (slow_clk_in),
      .rise     (rise)
   );

   // Period counter: restarts at 1 on each edge, saturates when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Period classification and fault events; a tick beats a timeout.
   always_comb begin
      good_per = in_window(32'(cnt), LO_I, HI_I);
      timeout  = (state != ACQUIRE) && !rise && (cnt >= HI);
      fault_ev = timeout || (rise && (state != ACQUIRE) && !good_per);
   end

   // Lock FSM with registered tick, period and lock outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ACQUIRE;
         good_cnt     <= '0;
         tick         <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
      end else begin
         tick         <= rise;
         period_valid <= 1'b0;
         case (state)
            ACQUIRE: begin
               if (rise) begin
                  state    <= MEASURE;
                  good_cnt <= '0;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  if (good_per) begin
                     if (good_cnt == LOCK_LAST) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                     good_cnt <= good_cnt + 4'd1;
                  end else begin
                     good_cnt <= '0;
                  end
               end else if (timeout) begin
                  state    <= ACQUIRE;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
            end
            LOCKED: begin
               if (rise) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  if (!good_per) begin
                     state    <= MEASURE;
                     good_cnt <= '0;
                     locked   <= 1'b0;
                  end
               end else if (timeout) begin
                  state    <= ACQUIRE;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
            end
            default: begin
               state    <= ACQUIRE;
               good_cnt <= '0;
               locked   <= 1'b0;
            end
         endcase
      end
   end

`ifdef SLOW_CLK_MON_STICKY_FAULT_EN
   // Sticky fault: a new event wins over a concurrent clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault <= 1'b0;
      end else if (fault_ev) begin
         fault <= 1'b1;
      end else if (clr_fault) begin
         fault <= 1'b0;
      end
   end
`else
   logic unused_clr_fault;
   assign unused_clr_fault = clr_fault;

   // Pulsed fault: one cycle per event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault <= 1'b0;
      end else begin
         fault <= fault_ev;
      end
   end
`endif

endmodule
